// File: rtl/aes_mixcol_iter.sv
// Iterative AES MixColumns / InvMixColumns engine over the full 128-bit state.
// Transforms COLS_PER_CYCLE columns per BUSY cycle, in place in st.
module aes_mixcol_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         inv_i,
  input  logic [127:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] data_o
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
      COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [3:0] GMASK =
    4'((1 << COLS_PER_CYCLE) - 1);

  state_t       state;
  logic         mode;
  logic [1:0]   cnt;
  logic [127:0] st;
  logic [127:0] st_nxt;
  logic [2:0]   cnt_end;
  logic [3:0]   grp;

  function automatic logic [7:0] xt(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

  function automatic logic [31:0] mix_col(
    input logic [31:0] c,
    input logic        inv
  );
    logic [7:0] b  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m  [4];
    for (int r = 0; r < 4; r++) begin
      b[r]  = c[8*r +: 8];
      x2[r] = xt(b[r]);
      x4[r] = xt(x2[r]);
      x8[r] = xt(x4[r]);
    end
    // row r mixes b[r], b[r+1], b[r+2], b[r+3] with rotated coefficients
    for (int r = 0; r < 4; r++) begin
      if (!inv) begin
        m[r] = x2[r]
             ^ x2[(r+1)%4] ^ b[(r+1)%4]
             ^ b[(r+2)%4]
             ^ b[(r+3)%4];
      end else begin
        m[r] = (x8[r] ^ x4[r] ^ x2[r])
             ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ b[(r+1)%4])
             ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ b[(r+2)%4])
             ^ (x8[(r+3)%4] ^ b[(r+3)%4]);
      end
    end
    return {m[3], m[2], m[1], m[0]};
  endfunction

  assign cnt_end = {1'b0, cnt} + 3'(COLS_PER_CYCLE);
  assign grp     = GMASK << cnt;

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign st_nxt[32*c +: 32] = grp[c]
      ? mix_col(st[32*c +: 32], mode)
      : st[32*c +: 32];
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IDLE;
      cnt   <= 2'd0;
      mode  <= 1'b0;
      st    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            st    <= data_i;
            mode  <= inv_i;
            cnt   <= 2'd0;
            state <= BUSY;
          end
        end
        BUSY: begin
          st  <= st_nxt;
          cnt <= cnt_end[1:0];
          if (cnt_end[2]) state <= DONE;
        end
        DONE: begin
          if (ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);
  assign data_o  = st;

endmodule

// File: tb/tb_aes_mixcol_iter.sv
// Directed and round-trip bench for aes_mixcol_iter.
// One instance per legal COLS_PER_CYCLE value (1, 2, 4).
module tb_aes_mixcol_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nreset;
  logic         valid_i [3];
  logic         inv_i   [3];
  logic         ready_i [3];
  logic         ready_o [3];
  logic         valid_o [3];
  logic [127:0] data_i  [3];
  logic [127:0] data_o  [3];

  int errs   = 0;
  int checks = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_mixcol_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk     (clk),
      .nreset  (nreset),
      .valid_i (valid_i[g]),
      .ready_o (ready_o[g]),
      .inv_i   (inv_i[g]),
      .data_i  (data_i[g]),
      .valid_o (valid_o[g]),
      .ready_i (ready_i[g]),
      .data_o  (data_o[g])
    );
  end

  typedef struct {
    logic         inv;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input int k,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %h expected %h",
               nm, k, act, exp);
    end
  endtask

  task automatic xfer(input int k, input logic inv,
                      input logic [127:0] din,
                      input bit noise,
                      output logic [127:0] dout,
                      output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready_o[k] && w < 20) begin
      @(negedge clk);
      w++;
    end
    valid_i[k] = 1'b1;
    inv_i[k]   = inv;
    data_i[k]  = din;
    ready_i[k] = 1'b1;
    @(posedge clk);
    #1;
    valid_i[k] = noise;
    if (noise) begin
      inv_i[k]  = ~inv;
      data_i[k] = ~din;
    end
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (valid_o[k]) break;
      if (noise) begin
        valid_i[k] = ~valid_i[k];
        inv_i[k]   = ~inv_i[k];
        data_i[k]  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    valid_i[k] = 1'b0;
    dout = data_o[k];
    @(posedge clk);
    #1;
  endtask

  task automatic bp(input int k);
    int lat;
    @(negedge clk);
    valid_i[k] = 1'b1;
    inv_i[k]   = 1'b0;
    data_i[k]  = tbl[0].din;
    ready_i[k] = 1'b0;
    @(posedge clk);
    #1;
    valid_i[k] = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (valid_o[k]) break;
    end
    chk("bp_lat", k, 128'(lat), 128'(4 >> k));
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      valid_i[k] = (j % 2 == 0);
      inv_i[k]   = (j % 2 == 1);
      data_i[k]  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      chk("bp_data", k, data_o[k], tbl[0].exp);
      chk("bp_ready", k, 128'(ready_o[k]), 128'(0));
      chk("bp_valid", k, 128'(valid_o[k]), 128'(1));
    end
    @(negedge clk);
    ready_i[k] = 1'b1;
    valid_i[k] = 1'b1;
    inv_i[k]   = 1'b1;
    data_i[k]  = tbl[1].din;
    @(posedge clk);
    #1;
    chk("bp_rel_ready", k, 128'(ready_o[k]), 128'(1));
    chk("bp_rel_valid", k, 128'(valid_o[k]), 128'(0));
    @(posedge clk);
    #1;
    valid_i[k] = 1'b0;
    chk("bp_acc_ready", k, 128'(ready_o[k]), 128'(0));
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (valid_o[k]) break;
    end
    chk("bp_next_lat", k, 128'(lat), 128'(4 >> k));
    chk("bp_next_data", k, data_o[k], tbl[1].exp);
    @(posedge clk);
    #1;
  endtask

  task automatic rt(input int k);
    logic [127:0] s, f, r;
    int l1, l2;
    for (int i = 0; i < 1000; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      xfer(k, 1'b0, s, (i % 3 == 0), f, l1);
      xfer(k, 1'b1, f, 1'b0, r, l2);
      chk("rt_data", k, r, s);
      chk("rt_fwd_lat", k, 128'(l1), 128'(4 >> k));
      chk("rt_inv_lat", k, 128'(l2), 128'(4 >> k));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    int lat;

    tbl[0] = '{1'b0,
      128'hd5d4d4d4_01010101_5c220af2_455313db,
      128'hd6d7d5d5_01010101_9d58dc9f_bca14d8e};
    tbl[1] = '{1'b1,
      128'h00000000_00000000_00000000_f8bd7e4d,
      128'h00000000_00000000_00000000_4c31262d};
    tbl[2] = '{1'b1,
      128'hd6d7d5d5_01010101_9d58dc9f_bca14d8e,
      128'hd5d4d4d4_01010101_5c220af2_455313db};
    tbl[3] = '{1'b0, 128'h0, 128'h0};
    tbl[4] = '{1'b0,
      128'h00000000_00000001_00000000_00000000,
      128'h00000000_03010102_00000000_00000000};
    tbl[5] = '{1'b1,
      128'h00000000_00000000_00000001_00000000,
      128'h00000000_00000000_0b0d090e_00000000};
    tbl[6] = '{1'b0,
      128'hc6c6c6c6_00000000_00000000_01010101,
      128'hc6c6c6c6_00000000_00000000_01010101};

    nreset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid_i[k] = 1'b0;
      inv_i[k]   = 1'b0;
      ready_i[k] = 1'b0;
      data_i[k]  = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", k, 128'(ready_o[k]), 128'(1));
      chk("rst_valid", k, 128'(valid_o[k]), 128'(0));
      chk("rst_data", k, data_o[k], 128'h0);
    end
    @(negedge clk);
    nreset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 3; k++) begin
        xfer(k, tbl[i].inv, tbl[i].din, 1'b0, d, lat);
        chk($sformatf("vec%0d_data", i), k, d, tbl[i].exp);
        chk($sformatf("vec%0d_lat", i), k,
            128'(lat), 128'(4 >> k));
      end
    end

    for (int k = 0; k < 3; k++) begin
      xfer(k, 1'b0, tbl[0].din, 1'b1, d, lat);
      chk("latch_fwd", k, d, tbl[0].exp);
      xfer(k, 1'b1, tbl[1].din, 1'b1, d, lat);
      chk("latch_inv", k, d, tbl[1].exp);
    end

    bp(0);
    bp(2);

    @(negedge clk);
    valid_i[0] = 1'b1;
    inv_i[0]   = 1'b0;
    data_i[0]  = tbl[0].din;
    ready_i[0] = 1'b1;
    @(posedge clk);
    #1;
    valid_i[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_partial", 0, data_o[0],
        128'hd5d4d4d4_01010101_9d58dc9f_bca14d8e);
    @(negedge clk);
    nreset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", 0, 128'(ready_o[0]), 128'(1));
    chk("mid_rst_valid", 0, 128'(valid_o[0]), 128'(0));
    chk("mid_rst_data", 0, data_o[0], 128'h0);
    @(negedge clk);
    nreset = 1'b1;
    xfer(0, tbl[2].inv, tbl[2].din, 1'b0, d, lat);
    chk("mid_after_data", 0, d, tbl[2].exp);
    chk("mid_after_lat", 0, 128'(lat), 128'(4));

    fork
      rt(0);
      rt(1);
      rt(2);
    join

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
